// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor. One decimal digit per clock,
// least significant first, through a single shared correction stage.
// Subtraction adds the nine's complement of b with an initial carry of 1.
//
// Handshake: start is sampled only in IDLE. busy is high whenever the
// machine is not in IDLE. done pulses for one cycle with sum/cout/err valid.
// sum/cout/err hold until the next accepted start.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic [1:0]          dbg_state_o
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            operands_ok;
  logic [3:0]      a_dig, b_dig, b_eff, dig;
  logic [4:0]      t, t_minus;
  logic            c_nxt;
  int              idx;

  // Operand check on the inputs being accepted: every nibble must be 0..9.
  always_comb begin
    operands_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) operands_ok = 1'b0;
    end
  end

  // Shared digit stage: selects digit cnt_q, adds with carry, corrects mod 10.
  always_comb begin
    idx     = int'(cnt_q) * 4;
    a_dig   = a_q[idx +: 4];
    b_dig   = b_q[idx +: 4];
    b_eff   = mode_q ? (4'd9 - b_dig) : b_dig;
    t       = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    t_minus = t - 5'd10;
    if (t >= 5'd10) begin
      dig   = t_minus[3:0];
      c_nxt = 1'b1;
    end else begin
      dig   = t[3:0];
      c_nxt = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          carry_d = mode;
          if (operands_ok) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        sum_d[idx +: 4] = dig;
        carry_d         = c_nxt;
        cnt_d           = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          // A final carry of 1 in subtract mode means no borrow occurred.
          cout_d  = mode_q ? ~c_nxt : c_nxt;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: a 4-digit and a 1-digit instance share clock
// and reset. Expected {err,cout,sum} come from an integer decimal model.
module tb_bcd_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start4 = 0, mode4 = 0;
  logic [15:0] a4 = '0, b4 = '0, sum4;
  logic        busy4, done4, cout4, err4;
  logic [1:0]  dbg4;

  logic        start1 = 0, mode1 = 0;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  logic        busy1, done1, cout1, err1;
  logic [1:0]  dbg1;

  bcd_serial_adder #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4),
    .dbg_state_o(dbg4)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1),
    .dbg_state_o(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp4_q[$];
  logic [5:0]  exp1_q[$];
  int checks = 0;
  int errors = 0;

  // Decimal reference: returns {err, cout, sum[15:0]} for nd digits.
  function automatic logic [17:0] model(input logic m, input logic [15:0] x,
                                        input logic [15:0] y, input int nd);
    int xa, yb, r, pw;
    logic bad, c;
    logic [15:0] s;
    xa = 0; yb = 0; pw = 1; bad = 1'b0; s = '0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
      xa = xa * 10 + int'(x[4*i +: 4]);
      yb = yb * 10 + int'(y[4*i +: 4]);
      pw = pw * 10;
    end
    if (bad) return {1'b1, 1'b0, 16'h0000};
    if (!m) begin
      r = xa + yb;
      c = (r >= pw);
      r = r % pw;
    end else begin
      c = (xa < yb);
      r = (xa - yb + pw) % pw;
    end
    for (int i = 0; i < nd; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, c, s};
  endfunction

  function automatic logic [15:0] rand_bcd4();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- driver / collector for the 4-digit instance ----------------
  // Waits for done starting from j0 cycles after the accept edge, checks
  // latency, result, single-cycle pulse and that results hold afterwards.
  task automatic wait_done4(input int j0, input int exp_lat);
    int j;
    logic [17:0] exp;
    j = j0;
    while (done4 !== 1'b1 && j < 20) begin
      @(posedge clk); @(negedge clk); j++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout4 observed done=%b after %0d cycles, required 1", done4, j);
      return;
    end
    checks++;
    if (j !== exp_lat) begin
      errors++;
      $display("FAIL latency4 observed %0d required %0d", j, exp_lat);
    end
    checks++;
    if (exp4_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard4 observed done with empty queue, required pending entry");
      return;
    end
    exp = exp4_q.pop_front();
    if ({err4, cout4, sum4} !== exp) begin
      errors++;
      $display("FAIL result4 observed err=%b cout=%b sum=%h required err=%b cout=%b sum=%h",
               err4, cout4, sum4, exp[17], exp[16], exp[15:0]);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL pulse4 observed done=%b busy=%b required done=0 busy=0", done4, busy4);
    end
    checks++;
    if ({err4, cout4, sum4} !== exp) begin
      errors++;
      $display("FAIL hold4 observed err=%b cout=%b sum=%h required err=%b cout=%b sum=%h",
               err4, cout4, sum4, exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic run_op4(input logic m, input logic [15:0] x, input logic [15:0] y);
    logic [17:0] e;
    @(negedge clk);
    mode4 = m; a4 = x; b4 = y; start4 = 1'b1;
    e = model(m, x, y, 4);
    exp4_q.push_back(e);
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept4 observed %b required 1", busy4);
    end
    wait_done4(0, e[17] ? 0 : 4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy4, done4, cout4, err4, sum4} !== 20'h0) begin
      errors++;
      $display("FAIL reset4 observed busy=%b done=%b cout=%b err=%b sum=%h required all 0",
               busy4, done4, cout4, err4, sum4);
    end
    checks++;
    if ({busy1, done1, cout1, err1, sum1} !== 8'h0) begin
      errors++;
      $display("FAIL reset1 observed busy=%b done=%b cout=%b err=%b sum=%h required all 0",
               busy1, done1, cout1, err1, sum1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_op4(1'b0, 16'h1234, 16'h5678);
    run_op4(1'b0, 16'h9999, 16'h0001);
    run_op4(1'b0, 16'h0505, 16'h0505);
    run_op4(1'b0, 16'h9999, 16'h9999);
  endtask

  task automatic test_sub();
    run_op4(1'b1, 16'h0100, 16'h0001);
    run_op4(1'b1, 16'h0001, 16'h0002);
    run_op4(1'b1, 16'h4321, 16'h4321);
    run_op4(1'b1, 16'h0000, 16'h9999);
  endtask

  task automatic test_error();
    run_op4(1'b0, 16'h00A0, 16'h0001);
    run_op4(1'b0, 16'h0001, 16'h0001);   // valid start must clear err
    run_op4(1'b1, 16'h1234, 16'hF000);
    run_op4(1'b1, 16'h0050, 16'h0020);
  endtask

  task automatic test_handshake();
    @(negedge clk);
    mode4 = 1'b0; a4 = 16'h1234; b4 = 16'h5678; start4 = 1'b1;
    exp4_q.push_back(model(1'b0, 16'h1234, 16'h5678, 4));
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    start4 = 1'b1; mode4 = 1'b1; a4 = 16'h9999; b4 = 16'h8888;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    wait_done4(2, 4);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    mode4 = 1'b0; a4 = 16'h1234; b4 = 16'h5678; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (sum4 !== 16'h0012 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL partial4 observed sum=%h busy=%b required sum=0012 busy=1", sum4, busy4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, cout4, err4, sum4} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_run4 observed busy=%b done=%b cout=%b err=%b sum=%h required all 0",
               busy4, done4, cout4, err4, sum4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op4(1'b0, 16'h2468, 16'h1357);
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs[3];
    logic [15:0] ys[3];
    logic        ms[3];
    logic [17:0] exp;
    int last_done, guard;
    xs[0] = 16'h1111; ys[0] = 16'h8889; ms[0] = 1'b0;
    xs[1] = 16'h5000; ys[1] = 16'h5001; ms[1] = 1'b1;
    xs[2] = 16'h0909; ys[2] = 16'h0101; ms[2] = 1'b0;
    last_done = 0;
    @(negedge clk);
    mode4 = ms[0]; a4 = xs[0]; b4 = ys[0]; start4 = 1'b1;
    exp4_q.push_back(model(ms[0], xs[0], ys[0], 4));
    for (int n = 0; n < 3; n++) begin
      guard = 0;
      do begin
        @(posedge clk); @(negedge clk); guard++;
      end while (busy4 !== 1'b1 && guard < 20);
      // Accepted: present the next operands (or release start) right away.
      if (n < 2) begin
        mode4 = ms[n+1]; a4 = xs[n+1]; b4 = ys[n+1];
        exp4_q.push_back(model(ms[n+1], xs[n+1], ys[n+1], 4));
      end else begin
        start4 = 1'b0;
      end
      guard = 0;
      while (done4 !== 1'b1 && guard < 20) begin
        @(posedge clk); @(negedge clk); guard++;
      end
      checks++;
      if (done4 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_timeout op=%0d observed done=%b required 1", n, done4);
        start4 = 1'b0;
        return;
      end
      exp = exp4_q.pop_front();
      checks++;
      if ({err4, cout4, sum4} !== exp) begin
        errors++;
        $display("FAIL b2b_result op=%0d observed err=%b cout=%b sum=%h required err=%b cout=%b sum=%h",
                 n, err4, cout4, sum4, exp[17], exp[16], exp[15:0]);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last_done !== 6) begin
          errors++;
          $display("FAIL b2b_interval op=%0d observed %0d cycles required 6", n, cyc - last_done);
        end
      end
      last_done = cyc;
    end
    exp4_q.delete();
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle observed busy=%b required 0", busy4);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_op4(1'($urandom_range(0, 1)), rand_bcd4(), rand_bcd4());
    end
  endtask

  task automatic test_digits1();
    logic [3:0] xs[4];
    logic [3:0] ys[4];
    logic       ms[4];
    logic [17:0] r;
    logic [5:0]  exp;
    int j;
    xs[0] = 4'd9; ys[0] = 4'd9; ms[0] = 1'b0;
    xs[1] = 4'd9; ys[1] = 4'd9; ms[1] = 1'b1;
    xs[2] = 4'd3; ys[2] = 4'd7; ms[2] = 1'b1;
    xs[3] = 4'hC; ys[3] = 4'd1; ms[3] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      mode1 = ms[n]; a1 = xs[n]; b1 = ys[n]; start1 = 1'b1;
      r = model(ms[n], {12'h000, xs[n]}, {12'h000, ys[n]}, 1);
      exp1_q.push_back({r[17], r[16], r[3:0]});
      @(posedge clk); @(negedge clk);
      start1 = 1'b0;
      j = 0;
      while (done1 !== 1'b1 && j < 10) begin
        @(posedge clk); @(negedge clk); j++;
      end
      checks++;
      if (done1 !== 1'b1) begin
        errors++;
        $display("FAIL done_timeout1 op=%0d observed done=%b required 1", n, done1);
        exp1_q.delete();
        continue;
      end
      exp = exp1_q.pop_front();
      checks++;
      if (j !== (exp[5] ? 0 : 1)) begin
        errors++;
        $display("FAIL latency1 op=%0d observed %0d required %0d", n, j, exp[5] ? 0 : 1);
      end
      checks++;
      if ({err1, cout1, sum1} !== exp) begin
        errors++;
        $display("FAIL result1 op=%0d observed err=%b cout=%b sum=%h required err=%b cout=%b sum=%h",
                 n, err1, cout1, sum1, exp[5], exp[4], exp[3:0]);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_error();
    test_handshake();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_digits1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
